// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
//   NUM_REGS / REG_ADDR_W / REG_DATA_W : register block geometry
//   wb_req_t                           : one queued write (addr, data)
//   RF_WR_IDLE                         : rf_wr_n value that writes nothing
//   dec_addr()                         : one-hot register decode, addr 0 -> no bit
package regfile_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    localparam logic [NUM_REGS-1:0] RF_WR_IDLE = {NUM_REGS{1'b1}};

    // Register 0 is hard-wired, so its decode is empty.
    function automatic logic [NUM_REGS-1:0] dec_addr(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] onehot;
        onehot = '0;
        if (addr != '0) begin
            onehot = NUM_REGS'(1) << addr;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bus: requester handshakes, control, register-block drive.
//   master : requester/control side (drives req_*, freeze, flush)
//   slave  : scheduler side (drives req_ready, rf_wr_n, rf_wr_data, pending_mask, busy)
interface regfile_wb_scheduler_if
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][REG_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               freeze;
    logic                               flush;
    logic [NUM_REGS-1:0]                rf_wr_n;
    logic [REG_DATA_W-1:0]              rf_wr_data;
    logic [NUM_REGS-1:0]                pending_mask;
    logic                               busy;

    modport master (
        output req_valid, req_addr, req_data, freeze, flush,
        input  req_ready, rf_wr_n, rf_wr_data, pending_mask, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, freeze, flush,
        output req_ready, rf_wr_n, rf_wr_data, pending_mask, busy
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-requester in-order write FIFO.
//   clk, reset     : clock, synchronous active-low reset
//   flush_i        : empty the FIFO, drop this cycle's push/pop
//   push_i/_data_i : enqueue (ignored when full)
//   pop_i          : dequeue head (ignored when empty)
//   head_o         : current head entry
//   full_o/empty_o/count_o : occupancy
//   addr_mask_d_o  : decoded targets of the entries valid after this edge
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic                              push_i,
    input  wb_req_t                           push_data_i,
    input  logic                              pop_i,
    output wb_req_t                           head_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [$clog2(DEPTH):0]            count_o,
    output logic [NUM_REGS-1:0]               addr_mask_d_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] rel;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Next-state occupancy mask, so the scheduler can register pending_mask directly.
    always_comb begin
        addr_mask_d_o = '0;
        rel           = '0;
        for (int s = 0; s < int'(DEPTH); s++) begin
            rel = PTR_W'(s) - rd_ptr_q;
            if ((CNT_W'(rel) < cnt_q) && !(do_pop && (PTR_W'(s) == rd_ptr_q))) begin
                addr_mask_d_o = addr_mask_d_o | dec_addr(mem_q[s].addr);
            end
        end
        if (do_push) begin
            addr_mask_d_o = addr_mask_d_o | dec_addr(push_data_i.addr);
        end
        if (flush_i) begin
            addr_mask_d_o = '0;
        end
    end

    // Pointers and count.
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: buffers per-requester writes and issues one register
// write per cycle onto the register block's active-low per-register strobes.
//   clk, reset : clock, synchronous active-low reset
//   bus        : regfile_wb_scheduler_if.slave (req_*, freeze, flush,
//                rf_wr_n, rf_wr_data, pending_mask, busy)
// Build option: RR_ARB_EN selects round-robin arbitration; otherwise the
// lowest-index non-empty requester wins.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [NUM_REGS-1:0]   wr_n_q, wr_n_d;
    logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;

    logic [NUM_REQ-1:0]    push;
    logic [NUM_REQ-1:0]    pop;
    logic [NUM_REQ-1:0]    full;
    logic [NUM_REQ-1:0]    empty;
    wb_req_t               push_req    [NUM_REQ];
    wb_req_t               head        [NUM_REQ];
    logic [CNT_W-1:0]      count       [NUM_REQ];
    logic [NUM_REGS-1:0]   fifo_mask_d [NUM_REQ];

    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;
    logic                  do_grant;
    logic                  remain;

    assign bus.req_ready = ~full & {NUM_REQ{~bus.flush}};
    assign push          = bus.req_valid & bus.req_ready;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        assign push_req[g] = '{addr: bus.req_addr[g], data: bus.req_data[g]};

        wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk           (clk),
            .reset         (reset),
            .flush_i       (bus.flush),
            .push_i        (push[g]),
            .push_data_i   (push_req[g]),
            .pop_i         (pop[g]),
            .head_o        (head[g]),
            .full_o        (full[g]),
            .empty_o       (empty[g]),
            .count_o       (count[g]),
            .addr_mask_d_o (fifo_mask_d[g])
        );
    end

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;

    // Search from the pointer; the smallest offset that is non-empty wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (!empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign rr_ptr_d = do_grant ? IDX_W'((32'(grant_idx) + 32'd1) % NUM_REQ) : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (!empty[i]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign do_grant = (state_q == ST_RUN) & ~bus.freeze & ~bus.flush & grant_vld;
    assign pop      = do_grant ? (NUM_REQ'(1) << grant_idx) : '0;

    // Next state and output stage.
    always_comb begin
        state_d   = state_q;
        wr_n_d    = RF_WR_IDLE;
        wr_data_d = wr_data_q;
        remain    = 1'b0;

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (count[i] != CNT_W'(pop[i])) begin
                remain = 1'b1;
            end
        end

        if (do_grant) begin
            // Address 0 decodes to nothing, leaving every strobe high.
            wr_n_d    = ~dec_addr(head[grant_idx].addr);
            wr_data_d = head[grant_idx].data;
        end

        case (state_q)
            ST_IDLE: if (|push) state_d = ST_RUN;
            ST_RUN:  if (!remain && !(|push)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    // Pending targets after this edge: queued entries plus the output stage.
    always_comb begin
        pend_d = ~wr_n_d;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pend_d = pend_d | fifo_mask_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wr_n_q    <= RF_WR_IDLE;
            wr_data_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_n_q    <= wr_n_d;
            wr_data_q <= wr_data_d;
            pend_q    <= pend_d;
        end
    end

    assign bus.rf_wr_n      = wr_n_q;
    assign bus.rf_wr_data   = wr_data_q;
    assign bus.pending_mask = pend_q;
    assign bus.busy         = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run, all checked against a queue-based transaction model.
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned FIFO_DEPTH = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    regfile_wb_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: one queue of {addr,data} per requester, the last issued strobe
    // vector and data, and the round-robin pointer.
    logic [36:0] mq [NUM_REQ][$];
    logic [31:0] m_wr_n;
    logic [31:0] m_data;
    int          m_rr;
    bit          m_acc [NUM_REQ];

    task automatic model_reset();
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            mq[r].delete();
            m_acc[r] = 1'b0;
        end
        m_wr_n = 32'hFFFF_FFFF;
        m_data = 32'h0;
        m_rr   = 0;
    endtask

    // Apply the current inputs to the model, then advance one clock.
    task automatic tick();
        int          g;
        int          r;
        logic [36:0] e;
        if (!reset) begin
            model_reset();
        end else begin
            g = -1;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                m_acc[i] = bus.req_valid[i] && (mq[i].size() < int'(FIFO_DEPTH)) && !bus.flush;
            end
            if (!bus.flush && !bus.freeze) begin
                for (int k = 0; k < int'(NUM_REQ); k++) begin
`ifdef RR_ARB_EN
                    r = (m_rr + k) % int'(NUM_REQ);
`else
                    r = k;
`endif
                    if (g < 0 && mq[r].size() != 0) g = r;
                end
            end
            m_wr_n = 32'hFFFF_FFFF;
            if (bus.flush) begin
                for (int i = 0; i < int'(NUM_REQ); i++) mq[i].delete();
            end else begin
                if (g >= 0) begin
                    e = mq[g].pop_front();
                    if (e[36:32] != 5'd0) m_wr_n[e[36:32]] = 1'b0;
                    m_data = e[31:0];
                    m_rr   = (g + 1) % int'(NUM_REQ);
                end
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    if (m_acc[i]) mq[i].push_back({bus.req_addr[i], bus.req_data[i]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [96:0] obs_vec();
        return {bus.rf_wr_n, bus.rf_wr_data, bus.pending_mask, bus.busy};
    endfunction

    function automatic logic [96:0] exp_vec();
        logic [31:0] p;
        logic        b;
        logic [36:0] e;
        p = ~m_wr_n;
        b = 1'b0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (mq[r].size() != 0) b = 1'b1;
            for (int i = 0; i < mq[r].size(); i++) begin
                e = mq[r][i];
                if (e[36:32] != 5'd0) p[e[36:32]] = 1'b1;
            end
        end
        return {m_wr_n, m_data, p, b};
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_ready();
        logic [NUM_REQ-1:0] rdy;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            rdy[r] = (mq[r].size() < int'(FIFO_DEPTH)) && !bus.flush;
        end
        return rdy;
    endfunction

    task automatic drive_idle();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.freeze    = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset         = 1'b0;
        bus.req_valid = '1;
        bus.req_addr  = {5'd9, 5'd3};
        bus.req_data  = {$urandom(), $urandom()};
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (obs_vec() !== {32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset c%0d: got %h want wr_n=ffffffff data=0 pend=0 busy=0", c, obs_vec());
            end
        end
        reset         = 1'b1;
        bus.req_valid = '0;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 11", bus.req_ready);
        end
    endtask

    task automatic test_single_write();
        int strobes;
        strobes = 0;
        drive_idle();
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = 5'd5;
        bus.req_data[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.req_valid = '0;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_write c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                vectors++;
                if (bus.pending_mask !== 32'h0000_0020 || bus.rf_wr_n !== 32'hFFFF_FFFF) begin
                    miscompares++;
                    $display("FAIL single_write_pend: got pend=%h wr_n=%h want 00000020/ffffffff",
                             bus.pending_mask, bus.rf_wr_n);
                end
            end
            if (bus.rf_wr_n !== 32'hFFFF_FFFF) begin
                strobes++;
                vectors++;
                if (c != 1 || bus.rf_wr_n !== 32'hFFFF_FFDF || bus.rf_wr_data !== 32'hDEAD_BEEF
                    || bus.pending_mask[5] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_write_strobe c%0d: got wr_n=%h data=%h pend=%h want c1 ffffffdf deadbeef bit5",
                             c, bus.rf_wr_n, bus.rf_wr_data, bus.pending_mask);
                end
            end
        end
        vectors++;
        if (strobes != 1) begin
            miscompares++;
            $display("FAIL single_write_count: got %0d strobes want 1", strobes);
        end
    endtask

    task automatic test_contention();
        int          sent [NUM_REQ];
        logic [4:0]  got [$];
        logic [4:0]  exp_order [8];
`ifdef RR_ARB_EN
        exp_order = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
`else
        exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd12, 5'd13, 5'd14};
`endif
        drive_idle();
        for (int r = 0; r < int'(NUM_REQ); r++) sent[r] = 0;
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < int'(NUM_REQ); r++) begin
                bus.req_valid[r] = (sent[r] < 4);
                bus.req_addr[r]  = 5'(r * 10 + 1 + sent[r]);
                bus.req_data[r]  = $urandom();
            end
            #1;
            vectors++;
            if (bus.req_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL contention_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready());
            end
            tick();
            for (int r = 0; r < int'(NUM_REQ); r++) if (m_acc[r]) sent[r]++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL contention c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            for (int k = 0; k < 32; k++) if (bus.rf_wr_n[k] === 1'b0) got.push_back(5'(k));
        end
        drive_idle();
        vectors++;
        if (got.size() != 8) begin
            miscompares++;
            $display("FAIL contention_count: got %0d grants want 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_order[i]) begin
                miscompares++;
                $display("FAIL contention_order[%0d]: got %0d want %0d", i, got[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_reg0();
        drive_idle();
        bus.req_valid   = 2'b10;
        bus.req_addr[1] = 5'd0;
        bus.req_data[1] = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.req_valid = '0;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reg0 c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (bus.rf_wr_n !== 32'hFFFF_FFFF || bus.pending_mask !== 32'h0) begin
                miscompares++;
                $display("FAIL reg0_quiet c%0d: got wr_n=%h pend=%h want ffffffff/0", c, bus.rf_wr_n, bus.pending_mask);
            end
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reg0_consumed: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] got [$];
        drive_idle();
        bus.freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.req_valid[0] = 1'b1;
            bus.req_addr[0]  = 5'(7 + c);
            bus.req_data[0]  = $urandom();
            #1;
            vectors++;
            if (bus.req_ready[0] !== (c < 2)) begin
                miscompares++;
                $display("FAIL backpressure_ready c%0d: got %b want %b", c, bus.req_ready[0], (c < 2));
            end
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL backpressure_fill c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        drive_idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL backpressure_drain c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            for (int k = 0; k < 32; k++) if (bus.rf_wr_n[k] === 1'b0) got.push_back(5'(k));
        end
        vectors++;
        if (got.size() != 2 || got[0] !== 5'd7 || got[1] !== 5'd8) begin
            miscompares++;
            $display("FAIL backpressure_order: got %0d grants first=%0d want 7,8",
                     got.size(), (got.size() > 0) ? got[0] : 5'd0);
        end
    endtask

    task automatic test_flush();
        drive_idle();
        bus.freeze    = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd13, 5'd3};
        bus.req_data  = {$urandom(), $urandom()};
        tick();
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = 5'd4;
        tick();
        bus.req_valid = '0;
        bus.freeze    = 1'b0;
        tick();
        vectors++;
        if (obs_vec() !== exp_vec() || bus.rf_wr_n === 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL flush_setup: got %h want %h with a strobe", obs_vec(), exp_vec());
        end
        bus.flush     = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_ready: got %b want 00", bus.req_ready);
        end
        tick();
        vectors++;
        if ({bus.rf_wr_n, bus.pending_mask, bus.busy} !== {32'hFFFF_FFFF, 32'h0, 1'b0}
            || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL flush_clear: got %h want %h", obs_vec(), exp_vec());
        end
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (bus.rf_wr_n !== 32'hFFFF_FFFF || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL flush_after c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        drive_idle();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < int'(NUM_REQ); r++) begin
                bus.req_valid[r] = ($urandom_range(0, 2) != 0);
                bus.req_addr[r]  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom());
                bus.req_data[r]  = $urandom();
            end
            bus.freeze = ($urandom_range(0, 4) == 0);
            bus.flush  = ($urandom_range(0, 29) == 0);
            #1;
            vectors++;
            if (bus.req_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL random_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready());
            end
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_single_write();
        test_contention();
        test_reg0();
        test_backpressure();
        test_flush();
        test_random();
        test_reset();
        test_single_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
